// File: rtl/bip_pkg.sv
// bip_pkg: shared BIP opcodes, widths and fetch FSM state encoding
package bip_pkg;
  localparam int OPCODE_WIDTH = 5;
  localparam int OPERAND_WIDTH = 11;
  localparam int INSTR_WIDTH = 16;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_STO = 5'b00001;
  localparam logic [4:0] OP_LD = 5'b00010;
  localparam logic [4:0] OP_LDI = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;
endpackage

// File: rtl/bip_program_counter.sv
// bip_program_counter: PC register with increment and reload to RESET_PC
module bip_program_counter #(
  parameter int PC_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                load,
  output logic [PC_WIDTH-1:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= RESET_PC;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/bip_fetch_control.sv
// bip_fetch_control: BIP fetch/sequencing FSM, instruction register and PC control
module bip_fetch_control #(
  parameter int PC_WIDTH = 11,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                restart,
  output logic [PC_WIDTH-1:0]                 prog_addr,
  output logic                                prog_rd,
  input  logic [INSTR_WIDTH-1:0]              prog_data,
  input  logic                                WrPC,
  output logic [bip_pkg::OPCODE_WIDTH-1:0]    Opcode,
  output logic [bip_pkg::OPERAND_WIDTH-1:0]   Operand,
  output logic                                instr_valid,
  output logic                                halted,
  output logic [PC_WIDTH-1:0]                 pc
);
  import bip_pkg::*;
  logic [2:0] state, nextState;
  logic [INSTR_WIDTH-1:0] ir;
  always_comb
    nextState = !enable ? state :
                state == ST_IDLE  ? ST_FETCH :
                state == ST_FETCH ? ST_LOAD :
                state == ST_LOAD  ? ST_EXEC :
                state == ST_EXEC  ? (WrPC ? ST_FETCH : ST_HALT) :
                restart ? ST_FETCH : ST_HALT;
  // IR resets to the HALT opcode so a stray execute can never advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      ir <= '0;
    end else begin
      state <= nextState;
      if (enable && state == ST_LOAD) ir <= prog_data;
    end
  bip_program_counter #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .inc(instr_valid && WrPC),
    .load(enable && state == ST_HALT && restart),
    .pc(pc)
  );
  assign prog_addr = pc;
  assign prog_rd = enable && state == ST_FETCH;
  assign instr_valid = enable && state == ST_EXEC;
  assign halted = state == ST_HALT;
  assign Opcode = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign Operand = ir[OPERAND_WIDTH-1:0];
endmodule

// File: tb/tb_bip_fetch_control.sv
// tb_bip_fetch_control: scenario tasks plus randomized programs against a program-order model
module tb_bip_fetch_control;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, enable = 0, restart = 0;
  logic [10:0] prog_addr, pc, Operand;
  logic prog_rd, WrPC, instr_valid, halted;
  logic [15:0] prog_data = '0;
  logic [4:0] Opcode;
  logic [2:0] wAddr, wPc;
  logic wRd, wWrPC, wValid, wHalted;
  logic [15:0] wData = '0;
  logic [4:0] wOpcode;
  logic [10:0] wOperand;
  logic [15:0] rom [0:2047];
  int checks = 0, passed = 0;

  bip_fetch_control dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data), .WrPC(WrPC),
    .Opcode(Opcode), .Operand(Operand), .instr_valid(instr_valid), .halted(halted), .pc(pc)
  );
  bip_fetch_control #(.PC_WIDTH(3)) dutW (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .prog_addr(wAddr), .prog_rd(wRd), .prog_data(wData), .WrPC(wWrPC),
    .Opcode(wOpcode), .Operand(wOperand), .instr_valid(wValid), .halted(wHalted), .pc(wPc)
  );

  // synchronous program memories and a decoder model: opcodes 1..7 advance, all else halt
  always @(posedge clk) if (prog_rd) prog_data <= rom[prog_addr];
  always @(posedge clk) if (wRd) wData <= {5'b00011, 8'd0, wAddr};
  assign WrPC = Opcode != 5'd0 && Opcode < 5'd8;
  assign wWrPC = wOpcode != 5'd0 && wOpcode < 5'd8;

  task automatic do_reset();
    rst = 1; enable = 0; restart = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rom[0] = {5'b00011, 11'd9};
    rst = 1; enable = 1; restart = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 11'd0) $display("FAIL reset_pc got %0d want 0", pc); else passed++;
    checks++; if (prog_addr !== 11'd0) $display("FAIL reset_addr got %0d want 0", prog_addr); else passed++;
    checks++; if (prog_rd !== 1'b0) $display("FAIL reset_rd got %b want 0", prog_rd); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passed++;
    checks++; if ({Opcode, Operand} !== 16'd0) $display("FAIL reset_ir got %h want 0", {Opcode, Operand}); else passed++;
    rst = 0;
    @(negedge clk);
    checks++; if (prog_rd !== 1'b1 || prog_addr !== 11'd0) $display("FAIL start_fetch got rd=%b addr=%0d want rd=1 addr=0", prog_rd, prog_addr); else passed++;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) $display("FAIL start_load got valid=%b want 0", instr_valid); else passed++;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) $display("FAIL start_exec got valid=%b want 1", instr_valid); else passed++;
  endtask

  task automatic test_straight();
    logic [4:0] ops [3];
    ops = '{5'b00011, 5'b00101, 5'b00000};
    rom[0] = {5'b00011, 11'd5}; rom[1] = {5'b00101, 11'd3}; rom[2] = 16'd0;
    do_reset();
    enable = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++; if (instr_valid !== (c % 3 == 0 && c <= 9)) $display("FAIL straight_valid c=%0d got %b", c, instr_valid); else passed++;
      if (c % 3 == 0 && c <= 9) begin
        checks++; if (Opcode !== ops[c/3-1]) $display("FAIL straight_op c=%0d got %b want %b", c, Opcode, ops[c/3-1]); else passed++;
      end
      checks++; if (halted !== (c == 10)) $display("FAIL straight_halted c=%0d got %b", c, halted); else passed++;
    end
    checks++; if (pc !== 11'd2) $display("FAIL straight_pc got %0d want 2", pc); else passed++;
  endtask

  task automatic test_stall();
    logic [10:0] opnd;
    opnd = 11'($urandom);
    rom[0] = {5'b00011, opnd}; rom[1] = {5'b00011, 11'd1};
    do_reset();
    enable = 1;
    @(negedge clk);
    @(negedge clk);
    enable = 0;
    repeat (4) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0 || prog_rd !== 1'b0) $display("FAIL stall_quiet got valid=%b rd=%b want 0 0", instr_valid, prog_rd); else passed++;
      checks++; if (pc !== 11'd0) $display("FAIL stall_pc got %0d want 0", pc); else passed++;
    end
    enable = 1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) $display("FAIL stall_resume got valid=%b want 1", instr_valid); else passed++;
    checks++; if ({Opcode, Operand} !== rom[0]) $display("FAIL stall_ir got %h want %h", {Opcode, Operand}, rom[0]); else passed++;
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    do_reset();
    enable = 1;
    for (int cyc = 0; cyc < 120 && n < 20; cyc++) begin
      @(negedge clk);
      if (wValid) begin
        checks++; if (wPc !== 3'(n)) $display("FAIL wrap_pc n=%0d got %0d want %0d", n, wPc, n % 8); else passed++;
        n++;
      end
    end
    checks++; if (n != 20 || wHalted !== 1'b0) $display("FAIL wrap_run got %0d instr halted=%b want 20 instr halted=0", n, wHalted); else passed++;
  endtask

  task automatic test_restart();
    int cyc;
    rom[0] = {5'b00011, 11'd1}; rom[1] = 16'd0;
    do_reset();
    enable = 1;
    for (cyc = 0; cyc < 20 && halted !== 1'b1; cyc++) @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 11'd1 || prog_rd !== 1'b0) $display("FAIL restart_halt got halted=%b pc=%0d rd=%b want 1 1 0", halted, pc, prog_rd); else passed++;
    restart = 1;
    @(negedge clk);
    restart = 0;
    checks++; if (prog_rd !== 1'b1 || prog_addr !== 11'd0 || halted !== 1'b0) $display("FAIL restart_fetch got rd=%b addr=%0d halted=%b want 1 0 0", prog_rd, prog_addr, halted); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || Opcode !== 5'b00011) $display("FAIL restart_exec got valid=%b op=%b want 1 00011", instr_valid, Opcode); else passed++;
    restart = 1;
    @(negedge clk);
    restart = 0;
    checks++; if (prog_rd !== 1'b1 || prog_addr !== 11'd1) $display("FAIL restart_in_exec got rd=%b addr=%0d want 1 1", prog_rd, prog_addr); else passed++;
    repeat (3) @(negedge clk);
    enable = 0; restart = 1;
    @(negedge clk);
    restart = 0; enable = 1;
    checks++; if (halted !== 1'b1 || pc !== 11'd1) $display("FAIL restart_disabled got halted=%b pc=%0d want 1 1", halted, pc); else passed++;
  endtask

  task automatic test_illegal();
    rom[0] = {5'b11111, 11'($urandom)};
    do_reset();
    enable = 1;
    repeat (3) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || Opcode !== 5'b11111) $display("FAIL illegal_exec got valid=%b op=%b want 1 11111", instr_valid, Opcode); else passed++;
    @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 11'd0) $display("FAIL illegal_halt got halted=%b pc=%0d want 1 0", halted, pc); else passed++;
    rom[0] = {5'b00011, 11'd4}; rom[1] = {5'b00101, 11'd2};
    do_reset();
    enable = 1;
    repeat (6) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc !== 11'd1) $display("FAIL midop_exec got valid=%b pc=%0d want 1 1", instr_valid, pc); else passed++;
    #2 rst = 1;
    #1;
    checks++; if (instr_valid !== 1'b0 || pc !== 11'd0 || Opcode !== 5'd0) $display("FAIL midop_reset got valid=%b pc=%0d op=%b want 0 0 0", instr_valid, pc, Opcode); else passed++;
    @(negedge clk);
    rst = 0; enable = 0;
  endtask

  task automatic test_random();
    int len, n, cyc;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) rom[i] = {5'($urandom_range(1, 7)), 11'($urandom)};
      rom[len] = ($urandom % 2) ? {5'd0, 11'($urandom)} : {5'($urandom_range(8, 31)), 11'($urandom)};
      do_reset();
      n = 0;
      for (cyc = 0; cyc < 400 && halted !== 1'b1; cyc++) begin
        enable = ($urandom % 4) != 0;
        @(negedge clk);
        if (instr_valid === 1'b1) begin
          if (n > len) begin
            checks++; $display("FAIL rand_extra it=%0d got instr %0d want at most %0d", it, n, len + 1);
          end else begin
            checks++; if ({Opcode, Operand} !== rom[n] || pc !== 11'(n) || enable !== 1'b1) $display("FAIL rand_instr it=%0d n=%0d got ir=%h pc=%0d want ir=%h pc=%0d", it, n, {Opcode, Operand}, pc, rom[n], n); else passed++;
          end
          n++;
        end
      end
      enable = 1;
      checks++; if (halted !== 1'b1 || n != len + 1 || pc !== 11'(len)) $display("FAIL rand_end it=%0d got halted=%b count=%0d pc=%0d want 1 %0d %0d", it, halted, n, pc, len + 1, len); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'd0;
    test_reset();
    test_straight();
    test_stall();
    test_wrap();
    test_restart();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
